// File: rtl/dbg_cmd_parser.sv
// Debug command parser: turns a UART byte stream into single debug-bus
// transactions and streams a short response frame back to the UART.
// Frame in : SYNC, OPC, ADDR_HI, ADDR_LO, [DATA x4 for a write]
// Frame out: RSP, OPC, [RDATA x4 for a read]
module dbg_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter logic [7:0] RSP_BYTE     = 8'h5A,
    parameter int         IDLE_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        rxv,
    output logic        bus_req,
    output logic        bus_we,
    output logic [15:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [7:0]  txd,
    output logic        txv,
    input  logic        tx_rdy,
    output logic        err,
    output logic        drop
);

    localparam int               CNT_W   = $clog2(IDLE_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [7:0]       OPC_WR  = 8'h01;
    localparam logic [7:0]       OPC_RD  = 8'h02;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_ADDR,
        S_DATA,
        S_BUS,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_byte_cnt;
    logic [CNT_W-1:0]   r_idle_cnt;
    logic               r_req;
    logic               r_we;
    logic [15:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [7:0]         r_opc;
    logic [31:0]        r_rdata;
    logic [7:0]         r_txd;
    logic               r_txv;
    logic               r_err;
    logic               r_drop;

    logic               w_in_frame;
    logic               w_timeout;
    logic               w_tx_done;
    logic               w_bus_done;
    logic [2:0]         w_last_idx;
    logic               w_err;
    logic               w_drop;

    // Response byte selected by position: marker, echoed opcode, then read data MSB first.
    function automatic logic [7:0] rsp_byte(input logic [2:0]  idx,
                                            input logic [7:0]  opc,
                                            input logic [31:0] rdata);
        case (idx)
            3'd0:    rsp_byte = RSP_BYTE;
            3'd1:    rsp_byte = opc;
            3'd2:    rsp_byte = rdata[31:24];
            3'd3:    rsp_byte = rdata[23:16];
            3'd4:    rsp_byte = rdata[15:8];
            3'd5:    rsp_byte = rdata[7:0];
            default: rsp_byte = 8'h00;
        endcase
    endfunction

    assign w_in_frame = (r_state == S_OPC) || (r_state == S_ADDR) || (r_state == S_DATA);
    // An arriving byte always wins over an expiring timeout.
    assign w_timeout  = w_in_frame && !rxv && (r_idle_cnt == TO_LAST);
    assign w_tx_done  = r_txv && tx_rdy;
    assign w_bus_done = r_req && bus_ack;
    assign w_last_idx = r_we ? 3'd1 : 3'd5;

    // Next-state decode plus the error/drop conditions raised in each state.
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rxv && (rxd == SYNC_BYTE)) begin
                    w_next = S_OPC;
                end
            end
            S_OPC: begin
                if (rxv) begin
                    if ((rxd == OPC_WR) || (rxd == OPC_RD)) begin
                        w_next = S_ADDR;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_ADDR: begin
                if (rxv) begin
                    if (r_byte_cnt == 3'd1) begin
                        w_next = r_we ? S_DATA : S_BUS;
                    end
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rxv) begin
                    if (r_byte_cnt == 3'd3) begin
                        w_next = S_BUS;
                    end
                end else if (w_timeout) begin
                    w_err  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_BUS: begin
                w_drop = rxv;
                if (w_bus_done) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_drop = rxv;
                if (w_tx_done && (r_byte_cnt == w_last_idx)) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Byte counter restarts on every state change; counts rx bytes or accepted tx bytes.
    always_ff @(posedge clk) begin
        if (rst || (w_next != r_state)) begin
            r_byte_cnt <= 3'd0;
        end else if (((r_state == S_ADDR) || (r_state == S_DATA)) && rxv) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
        end else if ((r_state == S_RESP) && w_tx_done) begin
            r_byte_cnt <= r_byte_cnt + 3'd1;
        end
    end

    // Inter-byte idle counter; only runs inside a frame and saturates at the timeout point.
    always_ff @(posedge clk) begin
        if (rst || !w_in_frame || rxv || (w_next != r_state)) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TO_LAST) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Frame fields shift in MSB first; they only move outside BUS, so the request stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_opc   <= 8'h00;
            r_addr  <= 16'h0000;
            r_wdata <= 32'h0000_0000;
            r_rdata <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_OPC: begin
                    if (rxv && (w_next == S_ADDR)) begin
                        r_we  <= (rxd == OPC_WR);
                        r_opc <= rxd;
                    end
                end
                S_ADDR: begin
                    if (rxv) begin
                        r_addr <= {r_addr[7:0], rxd};
                    end
                end
                S_DATA: begin
                    if (rxv) begin
                        r_wdata <= {r_wdata[23:0], rxd};
                    end
                end
                S_BUS: begin
                    if (w_bus_done) begin
                        r_rdata <= bus_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus request rises the cycle after BUS entry and falls after the first sampled ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= 1'b0;
        end else begin
            r_req <= (r_state == S_BUS) && !w_bus_done;
        end
    end

    // Tx handshake: present a byte, hold it until accepted, then leave one idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txv <= 1'b0;
            r_txd <= 8'h00;
        end else if (r_state == S_RESP) begin
            if (!r_txv) begin
                r_txv <= 1'b1;
                r_txd <= rsp_byte(r_byte_cnt, r_opc, r_rdata);
            end else if (tx_rdy) begin
                r_txv <= 1'b0;
            end
        end else begin
            r_txv <= 1'b0;
        end
    end

    // Registered single-cycle error and drop pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_err  <= w_err;
            r_drop <= w_drop;
        end
    end

    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign txd       = r_txd;
    assign txv       = r_txv;
    assign err       = r_err;
    assign drop      = r_drop;

endmodule

// File: tb/tb_dbg_cmd_parser.sv
// Directed bench for dbg_cmd_parser: a table of complete transactions plus
// hand-written sequences for bad opcode, timeout, backpressure and reset.
module tb_dbg_cmd_parser;

    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rxd;
    logic        rxv;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [7:0]  txd;
    logic        txv;
    logic        tx_rdy;
    logic        err;
    logic        drop;

    logic [31:0] cyc = 32'd0;
    logic        rdy_toggle = 1'b0;

    int checks = 0;
    int failures = 0;

    // observation state maintained by the monitor
    logic [7:0]  tx_q[$];
    int          err_cnt = 0, drop_cnt = 0, req_cycles = 0;
    int          hold_viol = 0, req_unstable = 0, err_long = 0, drop_long = 0;
    logic        prev_hold = 1'b0, prev_err = 1'b0, prev_drop = 1'b0, prev_req = 1'b0;
    logic [7:0]  prev_txd = 8'h00;
    logic        cap_we = 1'b0;
    logic [15:0] cap_addr = 16'h0;
    logic [31:0] cap_wdata = 32'h0;

    // bus responder controls
    int          ack_dly = 1;
    int          req_age = 0;
    logic        force_ack = 1'b0;

    typedef struct {
        logic [7:0]  opc;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        int          exp_ntx;
        logic [47:0] exp_tx;
        int          exp_req;
    } vec_t;

    vec_t vecs[4];

    dbg_cmd_parser #(
        .SYNC_BYTE   (8'hA5),
        .RSP_BYTE    (8'h5A),
        .IDLE_TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .rxv      (rxv),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ack  (bus_ack),
        .bus_rdata(bus_rdata),
        .txd      (txd),
        .txv      (txv),
        .tx_rdy   (tx_rdy),
        .err      (err),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    assign tx_rdy = rdy_toggle ? cyc[0] : 1'b1;

    // Monitor: sampled on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (txv && tx_rdy) tx_q.push_back(txd);
        if (prev_hold && !rst && (!txv || (txd != prev_txd))) hold_viol++;
        prev_hold = txv && !tx_rdy;
        prev_txd  = txd;
        if (err) err_cnt++;
        if (err && prev_err) err_long++;
        prev_err = err;
        if (drop) drop_cnt++;
        if (drop && prev_drop) drop_long++;
        prev_drop = drop;
        if (bus_req) begin
            req_cycles++;
            if (!prev_req) begin
                cap_we    = bus_we;
                cap_addr  = bus_addr;
                cap_wdata = bus_wdata;
            end else if ((bus_we != cap_we) || (bus_addr != cap_addr) || (bus_wdata != cap_wdata)) begin
                req_unstable++;
            end
        end
        prev_req = bus_req;
    end

    // Bus responder: acks on the ack_dly-th cycle of a request, or constantly when forced.
    always @(negedge clk) begin
        if (bus_req) begin
            req_age++;
            bus_ack = (req_age == ack_dly) || force_ack;
        end else begin
            req_age = 0;
            bus_ack = force_ack;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxd = b;
        rxv = 1'b1;
        tick();
        rxv = 1'b0;
        rxd = 8'h00;
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [15:0] addr, input logic [31:0] wdata);
        send_byte(8'hA5);
        send_byte(opc);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        if (opc == 8'h01) begin
            send_byte(wdata[31:24]);
            send_byte(wdata[23:16]);
            send_byte(wdata[15:8]);
            send_byte(wdata[7:0]);
        end
    endtask

    task automatic wait_tx(input string name, input int n);
        int k;
        k = 0;
        while ((tx_q.size() < n) && (k < 300)) begin
            tick();
            k++;
        end
        check({name, "_tx_done"}, 64'(k < 300), 64'd1);
    endtask

    task automatic check_tx(input string name, input int n, input logic [47:0] exp);
        logic [47:0] got;
        got = 48'h0;
        foreach (tx_q[i]) got = {got[39:0], tx_q[i]};
        check({name, "_ntx"}, 64'(tx_q.size()), 64'(n));
        check({name, "_txbytes"}, 64'(got), 64'(exp));
    endtask

    initial begin
        int e0, d0, k;

        vecs[0] = '{8'h01, 16'h1234, 32'hDEADBEEF, 32'h0000_0000, 1, 2, 48'h5A01, 1};
        vecs[1] = '{8'h02, 16'h0010, 32'h0000_0000, 32'hCAFEF00D, 7, 6, 48'h5A02_CAFE_F00D, 7};
        vecs[2] = '{8'h02, 16'hFFFF, 32'h0000_0000, 32'h0000_0001, 3, 6, 48'h5A02_0000_0001, 3};
        vecs[3] = '{8'h01, 16'h0000, 32'h8000_0001, 32'h0000_0000, 2, 2, 48'h5A01, 2};

        rst = 1'b1;
        rxv = 1'b0;
        rxd = 8'h00;
        bus_rdata = 32'h0;
        repeat (3) tick();
        check("rst_bus_req", 64'(bus_req), 64'd0);
        check("rst_bus_we", 64'(bus_we), 64'd0);
        check("rst_bus_addr", 64'(bus_addr), 64'd0);
        check("rst_bus_wdata", 64'(bus_wdata), 64'd0);
        check("rst_txv_txd", 64'({txv, txd}), 64'd0);
        check("rst_err_drop", 64'({err, drop}), 64'd0);
        rst = 1'b0;
        tick();

        // Bad opcode, then a normal read
        e0 = err_cnt;
        req_cycles = 0;
        tx_q.delete();
        send_byte(8'hA5);
        send_byte(8'h07);
        repeat (3) tick();
        check("badopc_err", 64'(err_cnt - e0), 64'd1);
        check("badopc_noreq", 64'(req_cycles), 64'd0);
        bus_rdata = 32'h1234_5678;
        ack_dly = 1;
        send_frame(8'h02, 16'h0000, 32'h0);
        wait_tx("badopc_next", 6);
        check_tx("badopc_next", 6, 48'h5A02_1234_5678);
        check("badopc_next_we", 64'(cap_we), 64'd0);
        check("badopc_err_once", 64'(err_cnt - e0), 64'd1);

        // Timeout: err registered at the 50th silent edge
        e0 = err_cnt;
        req_cycles = 0;
        tx_q.delete();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h12);
        repeat (TO - 1) tick();
        check("to_not_early", 64'(err), 64'd0);
        tick();
        check("to_err", 64'(err), 64'd1);
        tick();
        check("to_err_1cyc", 64'(err), 64'd0);
        send_byte(8'h34);
        repeat (10) tick();
        check("to_err_count", 64'(err_cnt - e0), 64'd1);
        check("to_noreq", 64'(req_cycles), 64'd0);
        check("to_notx", 64'(tx_q.size()), 64'd0);

        // Byte arrives exactly on the timeout cycle: processed, no err
        e0 = err_cnt;
        tx_q.delete();
        bus_rdata = 32'h0BAD_F00D;
        send_byte(8'hA5);
        repeat (TO - 1) tick();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h40);
        wait_tx("coincide", 6);
        check_tx("coincide", 6, 48'h5A02_0BAD_F00D);
        check("coincide_addr", 64'(cap_addr), 64'h0040);
        check("coincide_noerr", 64'(err_cnt - e0), 64'd0);

        // Table-driven transactions, back to back
        for (int i = 0; i < 4; i++) begin
            tx_q.delete();
            req_cycles = 0;
            ack_dly = vecs[i].dly;
            bus_rdata = vecs[i].rdata;
            send_frame(vecs[i].opc, vecs[i].addr, vecs[i].wdata);
            wait_tx($sformatf("vec%0d", i), vecs[i].exp_ntx);
            check($sformatf("vec%0d_we", i), 64'(cap_we), 64'(vecs[i].opc == 8'h01));
            check($sformatf("vec%0d_addr", i), 64'(cap_addr), 64'(vecs[i].addr));
            if (vecs[i].opc == 8'h01) begin
                check($sformatf("vec%0d_wdata", i), 64'(cap_wdata), 64'(vecs[i].wdata));
            end
            check($sformatf("vec%0d_reqcyc", i), 64'(req_cycles), 64'(vecs[i].exp_req));
            check_tx($sformatf("vec%0d", i), vecs[i].exp_ntx, vecs[i].exp_tx);
        end

        // Backpressure with an rx byte injected during the response
        d0 = drop_cnt;
        tx_q.delete();
        rdy_toggle = 1'b1;
        ack_dly = 2;
        bus_rdata = 32'hA1B2_C3D4;
        send_frame(8'h02, 16'h0010, 32'h0);
        k = 0;
        while (!txv && (k < 100)) begin
            tick();
            k++;
        end
        check("bp_txv_seen", 64'(txv), 64'd1);
        send_byte(8'h55);
        wait_tx("bp", 6);
        repeat (4) tick();
        rdy_toggle = 1'b0;
        check_tx("bp", 6, 48'h5A02_A1B2_C3D4);
        check("bp_drop", 64'(drop_cnt - d0), 64'd1);

        // Reset while the bus request is outstanding
        tx_q.delete();
        ack_dly = 1000;
        send_frame(8'h01, 16'h0020, 32'h1122_3344);
        k = 0;
        while (!bus_req && (k < 100)) begin
            tick();
            k++;
        end
        check("rstbus_req_seen", 64'(bus_req), 64'd1);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rstbus_req_drop", 64'(bus_req), 64'd0);
        check("rstbus_txv", 64'(txv), 64'd0);
        check("rstbus_addr", 64'(bus_addr), 64'd0);
        rst = 1'b0;
        req_cycles = 0;
        force_ack = 1'b1;
        repeat (3) tick();
        force_ack = 1'b0;
        repeat (20) tick();
        check("rstbus_noreq", 64'(req_cycles), 64'd0);
        check("rstbus_notx", 64'(tx_q.size()), 64'd0);

        // Recovery after reset
        tx_q.delete();
        ack_dly = 1;
        bus_rdata = 32'h7654_3210;
        send_frame(8'h02, 16'hBEEF, 32'h0);
        wait_tx("recover", 6);
        check_tx("recover", 6, 48'h5A02_7654_3210);

        check("tx_hold_stable", 64'(hold_viol), 64'd0);
        check("req_fields_stable", 64'(req_unstable), 64'd0);
        check("err_single_cycle", 64'(err_long), 64'd0);
        check("drop_single_cycle", 64'(drop_long), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbg_cmd_parser.md
DBG_CMD_PARSER -- requirements
Module: dbg_cmd_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning the frame start marker.
REQ-002 SHALL have parameter RSP_BYTE, default 8'h5A, meaning the response start marker.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 100000, meaning the maximum number of clk cycles allowed between bytes of one frame.
REQ-004 SHALL have port clk  in  1  clock; all logic on posedge.
REQ-005 SHALL have port rst  in  1  reset; reset rst, synchronous, active-high; clock clk.
REQ-006 SHALL have ports rxd  in  8  and rxv  in  1: received byte plus a 1-cycle valid pulse from the UART receiver.
REQ-007 SHALL have ports bus_req  out  1, bus_we  out  1, bus_addr  out  16 and bus_wdata  out  32: the debug bus request.
REQ-008 SHALL have ports bus_ack  in  1 and bus_rdata  in  32: bus completion and read data.
REQ-009 SHALL have ports txd  out  8, txv  out  1 and tx_rdy  in  1: response byte stream to the UART transmitter.
REQ-010 SHALL have ports err  out  1 and drop  out  1: 1-cycle error and dropped-byte pulses.

Function
REQ-011 SHALL accept the frame format SYNC_BYTE, OPC, ADDR[15:8], ADDR[7:0], followed by DATA[31:24..7:0] when OPC = 8'h01 (write) and by nothing when OPC = 8'h02 (read).
REQ-012 SHALL implement the states IDLE, OPC, ADDR, DATA, BUS and RESP.
REQ-013 In IDLE, an rxv with rxd == SYNC_BYTE SHALL move the block to OPC; any other byte SHALL be ignored silently, with no err.
REQ-014 In OPC, an rxv with 8'h01 or 8'h02 SHALL latch bus_we (1 for 8'h01) and move the block to ADDR; any other value SHALL pulse err and move the block to IDLE.
REQ-015 ADDR SHALL take 2 bytes, MSB first, into bus_addr, then move to DATA for a write or to BUS for a read.
REQ-016 DATA SHALL take 4 bytes, MSB first, into bus_wdata, then move to BUS.
REQ-017 A 3-bit byte counter SHALL reset to 0 on each state entry.
REQ-018 bus_req SHALL assert on the cycle after BUS is entered and hold until the first cycle in which bus_ack is sampled high.
REQ-019 bus_addr, bus_we and bus_wdata SHALL remain stable while bus_req is high.
REQ-020 On bus_ack, the block SHALL deassert bus_req on the next cycle, capture bus_rdata for a read, and move to RESP.
REQ-021 A bus_ack seen while bus_req is low SHALL be ignored.
REQ-022 RESP SHALL emit RSP_BYTE, then OPC, then, for a read only, rdata MSB first: 2 bytes for a write, 6 for a read.
REQ-023 Tx handshake: txv high with txd stable SHALL hold until a cycle in which txv and tx_rdy are both high; the next byte SHALL be presented no earlier than the following cycle.
REQ-024 After the last byte is accepted, the block SHALL return to IDLE.
REQ-025 An rxv received in BUS or RESP SHALL be discarded and SHALL pulse drop for 1 cycle, with no state change.
REQ-026 In OPC, ADDR and DATA, the idle counter SHALL clear on every rxv and increment otherwise.
REQ-027 When the idle counter reaches IDLE_TIMEOUT-1 without an rxv, the block SHALL pulse err and move to IDLE; the counter SHALL saturate and never wrap.
REQ-028 BUS and RESP SHALL have no timeout.
REQ-029 err and drop SHALL be registered, and each pulse SHALL last exactly 1 cycle.
REQ-030 If rxv and a timeout coincide, the byte SHALL be processed and the timeout suppressed.
REQ-031 In IDLE, SYNC_BYTE SHALL be accepted immediately after the previous frame, with no gap required.

Reset
REQ-032 While rst is high, the block SHALL set state = IDLE, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, txv = 0, txd = 0, err = 0, drop = 0, and clear all counters.
REQ-033 A rst during BUS or RESP SHALL abort the frame, drop bus_req and txv on the next cycle, and emit no further response bytes.

Verification
REQ-034 Write: A5 01 12 34 DE AD BE EF with tx_rdy = 1 -> bus_req with bus_we = 1, addr 16'h1234, wdata 32'hDEADBEEF; after bus_ack, tx emits 5A 01.
REQ-035 Read: A5 02 00 10, bus_ack with bus_rdata = 32'hCAFEF00D delayed 7 cycles -> bus_req held 7 cycles; tx emits 5A 02 CA FE F0 0D.
REQ-036 Bad opcode: A5 07 -> err pulses once, no bus_req; a following A5 02 00 00 is processed normally.
REQ-037 Timeout with IDLE_TIMEOUT = 50: A5 01 12, then silence -> err on idle cycle 50 and state IDLE; a later 34 is ignored.
REQ-038 Backpressure: read with tx_rdy toggling every other cycle, plus one rxv injected during RESP -> 6 bytes in order with none duplicated, and drop pulses once.
REQ-039 Reset: rst asserted while bus_req is high -> bus_req = 0 next cycle; a subsequent bus_ack is ignored, and no tx bytes are emitted.
